// File: rtl/illm_lane_scatter_pkg.sv
// Shared definitions for the IDCT lane scatter block.
//   W_DEFAULT  : default coefficient width
//   LANES      : number of output lanes (one word per lane per row)
//   IDX_W      : width of the lane index counter
//   state_t    : scatter FSM states
//   lane_tok_t : one lane token at the default width {d, e}
package illm_lane_scatter_pkg;

    localparam int unsigned W_DEFAULT = 16;
    localparam int unsigned LANES     = 8;
    localparam int unsigned IDX_W     = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_EOS  = 2'd2
    } state_t;

    typedef struct packed {
        logic [W_DEFAULT-1:0] d;
        logic                 e;
    } lane_tok_t;

endpackage

// File: rtl/illm_lane_scatter_if.sv
// Stream bundle for the lane scatter block.
//   s_d/s_e/s_v/s_b : serial input stream (data, end token, valid, back-pressure)
//   a_d/a_e/a_v/a_b : per-lane output streams, element K is lane aK
//   err             : sticky mid-row end-of-stream flag
// Modports: master = stream producer / lane consumer side, slave = the scatter block.
interface illm_lane_scatter_if
    import illm_lane_scatter_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic [W-1:0]            s_d;
    logic                    s_e;
    logic                    s_v;
    logic                    s_b;
    logic [LANES-1:0][W-1:0] a_d;
    logic [LANES-1:0]        a_e;
    logic [LANES-1:0]        a_v;
    logic [LANES-1:0]        a_b;
    logic                    err;

    modport master (
        output s_d, s_e, s_v, a_b,
        input  s_b, a_d, a_e, a_v, err
    );

    modport slave (
        input  s_d, s_e, s_v, a_b,
        output s_b, a_d, a_e, a_v, err
    );
endinterface

// File: rtl/illm_lane_fifo.sv
// Per-lane token FIFO holding {e, d} entries.
//   clock, reset     : rising-edge clock, async active-high reset
//   push/push_d/push_e : write one token (ignored when full)
//   pop              : drop the head token (ignored when empty)
//   head_d/head_e    : head token, forced to zero while empty
//   full/empty       : registered occupancy flags
// Push and pop in the same cycle both take effect; occupancy is unchanged.
module illm_lane_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_d,
    input  logic         push_e,
    input  logic         pop,
    output logic [W-1:0] head_d,
    output logic         head_e,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W:0]  mem [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic [W:0]  head_w;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_q[AW-1:0]] <= {push_e, push_d};
    end

    assign empty  = (wr_q == rd_q);
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_w = mem[rd_q[AW-1:0]];
    assign head_d = empty ? '0 : head_w[W-1:0];
    assign head_e = !empty && head_w[W];
endmodule

// File: rtl/illm_lane_scatter.sv
// Scatters a serial coefficient stream onto 8 lane streams, one word per lane
// per row, and expands a single end-of-stream token into one end token per
// lane, zero-padding an incomplete row first.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of illm_lane_scatter_if (input stream, 8 lane streams, err)
// s_b is derived from registered state only (state, idx, FIFO full flags), so
// lane back-pressure never reaches the input combinationally.
module illm_lane_scatter
    import illm_lane_scatter_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    illm_lane_scatter_if.slave   bus
);
    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [LANES-1:0]        sent_q;
    logic [LANES-1:0]        sent_d;
    logic                    err_q;
    logic                    err_d;

    logic [LANES-1:0]        full;
    logic [LANES-1:0]        empty;
    logic [LANES-1:0]        push;
    logic [LANES-1:0]        pop;
    logic [LANES-1:0][W-1:0] head_d;
    logic [LANES-1:0]        head_e;
    logic [W-1:0]            wr_d;
    logic                    wr_e;
    logic                    take;
    logic                    s_b;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sent_d  = sent_q;
        err_d   = err_q;
        unique case (state_q)
            ST_FILL: begin
                if (take) begin
                    if (!bus.s_e) begin
                        idx_d = idx_q + 1'b1;
                    end else if (idx_q == '0) begin
                        state_d = ST_EOS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (!full[idx_q]) begin
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        idx_d   = '0;
                        state_d = ST_EOS;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_EOS: begin
                // Leave once every lane has taken its end token, including
                // the ones pushed this cycle.
                sent_d = sent_q | push;
                if (&sent_d) begin
                    sent_d  = '0;
                    idx_d   = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = '0;
                sent_d  = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic: input back-pressure and lane pushes
    // ---------------------------------------------------------------
    always_comb begin
        s_b  = 1'b1;
        take = 1'b0;
        push = '0;
        wr_d = '0;
        wr_e = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                s_b  = full[idx_q];
                take = bus.s_v && !full[idx_q];
                if (take && !bus.s_e) begin
                    push[idx_q] = 1'b1;
                    wr_d        = bus.s_d;
                end
            end
            ST_PAD: begin
                push[idx_q] = !full[idx_q];
            end
            ST_EOS: begin
                push = ~sent_q & ~full;
                wr_e = 1'b1;
            end
            default: begin
                s_b = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Lane FIFOs
    // ---------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        illm_lane_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock  (clock),
            .reset  (reset),
            .push   (push[k]),
            .push_d (wr_d),
            .push_e (wr_e),
            .pop    (pop[k]),
            .head_d (head_d[k]),
            .head_e (head_e[k]),
            .full   (full[k]),
            .empty  (empty[k])
        );
    end

    assign pop     = ~empty & ~bus.a_b;
    assign bus.a_v = ~empty;
    assign bus.a_d = head_d;
    assign bus.a_e = head_e;
    assign bus.s_b = s_b;
    assign bus.err = err_q;
endmodule

// File: tb/tb_illm_lane_scatter.sv
module tb_illm_lane_scatter;
    import illm_lane_scatter_pkg::*;

    localparam int BUDGET = 3000;

    logic clock;
    logic reset;

    illm_lane_scatter_if #(.W(16)) bus ();

    illm_lane_scatter #(.W(16), .DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Lane back-pressure: fixed pattern or per-cycle random, with an xor
    // overlay used to probe for combinational paths to s_b.
    logic       bp_rand;
    logic [7:0] bp_rnd;
    logic [7:0] ab_fix;
    logic [7:0] ab_flip;
    assign bus.a_b = (bp_rand ? bp_rnd : ab_fix) ^ ab_flip;

    initial begin
        bp_rnd = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 8; k++) bp_rnd[k] = ($urandom_range(0, 3) == 0);
        end
    end

    int n_cmp = 0;
    int n_mis = 0;
    int timeouts = 0;

    // Reference model: word n of a row belongs to lane n mod 8; an end token
    // at row position p pads lanes p..7 with zero words, then every lane gets
    // one end token. Observed lane tokens are collected alongside.
    lane_tok_t exp_q [8][$];
    lane_tok_t obs_q [8][$];
    int        m_pos = 0;
    bit        m_err = 0;
    int        clr_req = 0;
    int        clr_ack = 0;

    initial begin
        lane_tok_t t;
        forever begin
            @(negedge clock);
            if (reset) begin
                for (int k = 0; k < 8; k++) begin exp_q[k].delete(); obs_q[k].delete(); end
                m_pos = 0;
                m_err = 0;
            end else begin
                if (clr_req != clr_ack) begin
                    for (int k = 0; k < 8; k++) begin exp_q[k].delete(); obs_q[k].delete(); end
                    clr_ack = clr_req;
                end
                if (bus.s_v && !bus.s_b) begin
                    if (!bus.s_e) begin
                        t.d = bus.s_d; t.e = 1'b0;
                        exp_q[m_pos].push_back(t);
                        m_pos = (m_pos + 1) % 8;
                    end else begin
                        if (m_pos != 0) begin
                            m_err = 1;
                            t.d = '0; t.e = 1'b0;
                            for (int k = m_pos; k < 8; k++) exp_q[k].push_back(t);
                        end
                        t.d = '0; t.e = 1'b1;
                        for (int k = 0; k < 8; k++) exp_q[k].push_back(t);
                        m_pos = 0;
                    end
                end
                for (int k = 0; k < 8; k++) begin
                    if (bus.a_v[k] && !bus.a_b[k]) begin
                        t.d = bus.a_d[k]; t.e = bus.a_e[k];
                        obs_q[k].push_back(t);
                    end
                end
            end
        end
    end

    // Present one token and hold it until accepted; cyc = cycles taken.
    task automatic put_tok(input logic [15:0] d, input logic e, output int cyc);
        bit acc;
        acc = 0;
        cyc = 0;
        bus.s_d = d;
        bus.s_e = e;
        bus.s_v = 1'b1;
        while (!acc && cyc < BUDGET) begin
            @(negedge clock);
            acc = !bus.s_b;
            @(posedge clock);
            #1;
            cyc++;
        end
        bus.s_v = 1'b0;
        bus.s_e = 1'b0;
        if (!acc) timeouts++;
    endtask

    // Wait until every lane is empty and the input is open again.
    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < BUDGET && !idle; i++) begin
            @(negedge clock);
            idle = (bus.a_v == 8'h00) && !bus.s_b;
            @(posedge clock);
            #1;
        end
        if (!idle) timeouts++;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.s_b !== 1'b0) begin n_mis++; $display("FAIL reset_s_b got %b want 0", bus.s_b); end
        n_cmp++; if (bus.a_v !== 8'h00) begin n_mis++; $display("FAIL reset_a_v got %h want 00", bus.a_v); end
        n_cmp++; if (bus.a_e !== 8'h00) begin n_mis++; $display("FAIL reset_a_e got %h want 00", bus.a_e); end
        n_cmp++; if (bus.a_d !== '0) begin n_mis++; $display("FAIL reset_a_d got %h want 0", bus.a_d); end
        n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL reset_err got %b want 0", bus.err); end
    endtask

    task automatic test_basic();
        int c;
        int t0;
        t0 = timeouts;
        ab_fix = '0;
        for (int i = 1; i <= 16; i++) put_tok(16'(i), 1'b0, c);
        put_tok(16'h0000, 1'b1, c);
        wait_idle();
        n_cmp++; if (timeouts != t0) begin n_mis++; $display("FAIL basic_timeout got %0d want %0d", timeouts, t0); end
        n_cmp++; if (obs_q[0].size() != 3) begin n_mis++; $display("FAIL basic_a0_len got %0d want 3", obs_q[0].size()); end
        else begin
            n_cmp++; if (obs_q[0][1].d !== 16'h0009) begin n_mis++; $display("FAIL basic_a0_w1 got %h want 0009", obs_q[0][1].d); end
            n_cmp++; if (obs_q[0][2].e !== 1'b1) begin n_mis++; $display("FAIL basic_a0_e got %b want 1", obs_q[0][2].e); end
        end
        n_cmp++; if (obs_q[7].size() != 3) begin n_mis++; $display("FAIL basic_a7_len got %0d want 3", obs_q[7].size()); end
        else begin
            n_cmp++; if (obs_q[7][1].d !== 16'h0010) begin n_mis++; $display("FAIL basic_a7_w1 got %h want 0010", obs_q[7][1].d); end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                n_mis++; $display("FAIL basic_lane%0d_len got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < obs_q[k].size(); i++) begin
                    n_cmp++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        n_mis++; $display("FAIL basic_lane%0d_tok%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL basic_err got %b want 0", bus.err); end
        clr_req++;
    endtask

    task automatic test_backpressure();
        int c;
        int tot;
        int t0;
        t0 = timeouts;
        tot = 0;
        ab_fix = 8'h08;
        for (int i = 0; i < 19; i++) begin put_tok(16'h0100 + 16'(i), 1'b0, c); tot += c; end
        n_cmp++; if (tot != 19) begin n_mis++; $display("FAIL bp_nostall got %0d cycles want 19", tot); end
        // Word 19 targets lane 3, which now holds words 3 and 11.
        bus.s_d = 16'h0113; bus.s_e = 1'b0; bus.s_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (bus.s_b !== 1'b1) begin n_mis++; $display("FAIL bp_stall%0d got s_b=%b want 1", i, bus.s_b); end
            @(posedge clock);
            #1;
        end
        ab_fix = 8'h00;
        for (int i = 19; i < 24; i++) put_tok(16'h0100 + 16'(i), 1'b0, c);
        put_tok(16'h0000, 1'b1, c);
        wait_idle();
        n_cmp++; if (timeouts != t0) begin n_mis++; $display("FAIL bp_timeout got %0d want %0d", timeouts, t0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                n_mis++; $display("FAIL bp_lane%0d_len got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < obs_q[k].size(); i++) begin
                    n_cmp++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        n_mis++; $display("FAIL bp_lane%0d_tok%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        clr_req++;
    endtask

    task automatic test_mid_eos();
        int c;
        int t0;
        t0 = timeouts;
        ab_fix = '0;
        put_tok(16'h000A, 1'b0, c);
        put_tok(16'h000B, 1'b0, c);
        put_tok(16'h000C, 1'b0, c);
        put_tok(16'hBEEF, 1'b1, c);
        n_cmp++; if (bus.err !== 1'b1) begin n_mis++; $display("FAIL mid_err_set got %b want 1", bus.err); end
        wait_idle();
        n_cmp++; if (obs_q[3].size() != 2) begin n_mis++; $display("FAIL mid_a3_len got %0d want 2", obs_q[3].size()); end
        else begin
            n_cmp++; if (obs_q[3][0].d !== 16'h0000 || obs_q[3][0].e !== 1'b0) begin
                n_mis++; $display("FAIL mid_a3_pad got %h want 00000", obs_q[3][0]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                n_mis++; $display("FAIL mid_lane%0d_len got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < obs_q[k].size(); i++) begin
                    n_cmp++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        n_mis++; $display("FAIL mid_lane%0d_tok%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        // A clean aligned row afterwards must not clear the sticky flag.
        for (int i = 0; i < 8; i++) put_tok(16'h0200 + 16'(i), 1'b0, c);
        put_tok(16'h0000, 1'b1, c);
        wait_idle();
        n_cmp++; if (bus.err !== 1'b1) begin n_mis++; $display("FAIL mid_err_sticky got %b want 1", bus.err); end
        n_cmp++; if (timeouts != t0) begin n_mis++; $display("FAIL mid_timeout got %0d want %0d", timeouts, t0); end
        clr_req++;
    endtask

    task automatic test_eos_stall();
        int c;
        int t0;
        t0 = timeouts;
        ab_fix = 8'h20;
        for (int i = 0; i < 16; i++) put_tok(16'h0300 + 16'(i), 1'b0, c);
        put_tok(16'h0000, 1'b1, c);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++; if (bus.s_b !== 1'b1) begin n_mis++; $display("FAIL eos_stall_s_b%0d got %b want 1", i, bus.s_b); end
            n_cmp++; if (bus.a_v[5] !== 1'b1) begin n_mis++; $display("FAIL eos_stall_a5_v%0d got %b want 1", i, bus.a_v[5]); end
            @(posedge clock);
            #1;
        end
        for (int k = 0; k < 8; k++) begin
            if (k != 5) begin
                n_cmp++;
                if (obs_q[k].size() == 0 || obs_q[k][obs_q[k].size()-1].e !== 1'b1) begin
                    n_mis++; $display("FAIL eos_stall_lane%0d_e got len=%0d want last token e=1", k, obs_q[k].size());
                end
            end
        end
        n_cmp++; if (obs_q[5].size() != 0) begin n_mis++; $display("FAIL eos_stall_a5_held got %0d want 0", obs_q[5].size()); end
        ab_fix = 8'h00;
        wait_idle();
        n_cmp++; if (timeouts != t0) begin n_mis++; $display("FAIL eos_stall_timeout got %0d want %0d", timeouts, t0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                n_mis++; $display("FAIL eos_stall_lane%0d_len got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < obs_q[k].size(); i++) begin
                    n_cmp++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        n_mis++; $display("FAIL eos_stall_lane%0d_tok%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        clr_req++;
    endtask

    task automatic test_reset_mid();
        int c;
        int t0;
        t0 = timeouts;
        ab_fix = 8'hFF;
        for (int i = 0; i < 16; i++) put_tok(16'h0400 + 16'(i), 1'b0, c);
        @(negedge clock);
        n_cmp++; if (bus.a_v !== 8'hFF) begin n_mis++; $display("FAIL rstmid_full got %h want ff", bus.a_v); end
        n_cmp++; if (bus.s_b !== 1'b1) begin n_mis++; $display("FAIL rstmid_pre_s_b got %b want 1", bus.s_b); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.a_v !== 8'h00) begin n_mis++; $display("FAIL rstmid_a_v got %h want 00", bus.a_v); end
        n_cmp++; if (bus.s_b !== 1'b0) begin n_mis++; $display("FAIL rstmid_s_b got %b want 0", bus.s_b); end
        n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL rstmid_err got %b want 0", bus.err); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        put_tok(16'h0055, 1'b0, c);
        @(negedge clock);
        n_cmp++; if (bus.a_v !== 8'h01) begin n_mis++; $display("FAIL rstmid_lane0 got a_v=%h want 01", bus.a_v); end
        n_cmp++; if (bus.a_d[0] !== 16'h0055) begin n_mis++; $display("FAIL rstmid_a0_d got %h want 0055", bus.a_d[0]); end
        @(posedge clock);
        #1;
        ab_fix = 8'h00;
        for (int i = 1; i < 8; i++) put_tok(16'h0500 + 16'(i), 1'b0, c);
        put_tok(16'h0000, 1'b1, c);
        wait_idle();
        n_cmp++; if (timeouts != t0) begin n_mis++; $display("FAIL rstmid_timeout got %0d want %0d", timeouts, t0); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                n_mis++; $display("FAIL rstmid_lane%0d_len got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < obs_q[k].size(); i++) begin
                    n_cmp++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        n_mis++; $display("FAIL rstmid_lane%0d_tok%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        clr_req++;
    endtask

    task automatic test_random();
        int  c;
        int  n;
        int  t0;
        bit  mid;
        logic sb0;
        t0 = timeouts;
        bp_rand = 1'b1;
        for (int r = 0; r < 1000; r++) begin
            mid = ($urandom_range(0, 39) == 0);
            n = mid ? $urandom_range(1, 7) : 8;
            for (int i = 0; i < n; i++) put_tok(16'($urandom), 1'b0, c);
            if (mid || $urandom_range(0, 15) == 0) put_tok(16'($urandom), 1'b1, c);
            if (r % 10 == 0) begin
                // Flip every lane's back-pressure mid-cycle; s_b must not move.
                #1;
                sb0 = bus.s_b;
                ab_flip = 8'hFF;
                #1;
                n_cmp++; if (bus.s_b !== sb0) begin n_mis++; $display("FAIL rand_sb_indep row%0d got %b want %b", r, bus.s_b, sb0); end
                ab_flip = 8'h00;
                #1;
            end
        end
        put_tok(16'h0000, 1'b1, c);
        bp_rand = 1'b0;
        ab_fix = 8'h00;
        wait_idle();
        n_cmp++; if (timeouts != t0) begin n_mis++; $display("FAIL rand_timeout got %0d want %0d", timeouts, t0); end
        n_cmp++; if (bus.err !== logic'(m_err)) begin n_mis++; $display("FAIL rand_err got %b want %b", bus.err, m_err); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                n_mis++; $display("FAIL rand_lane%0d_len got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < obs_q[k].size(); i++) begin
                    n_cmp++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        n_mis++; $display("FAIL rand_lane%0d_tok%0d got %h want %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        clr_req++;
    endtask

    initial begin
        reset   = 1'b1;
        bp_rand = 1'b0;
        ab_fix  = '0;
        ab_flip = '0;
        bus.s_d = '0;
        bus.s_e = 1'b0;
        bus.s_v = 1'b0;
        #1;
        test_reset();
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        test_basic();
        test_backpressure();
        test_mid_eos();
        test_eos_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got time limit want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
